// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder:
// op encoding, FSM states and default geometry.
package dmem_responder_pkg;

  localparam int unsigned DMEM_ADDR_W = 8;
  localparam int unsigned DMEM_DATA_W = 8;
  localparam int unsigned DMEM_DEPTH  = 256;

  typedef enum logic [1:0] {
    RD  = 2'd0,
    WR  = 2'd1,
    INC = 2'd2,
    DEC = 2'd3
  } mem_op_t;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_READ,
    S_MODIFY,
    S_RESP
  } rsp_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the core and the
// data-memory responder.
interface dmem_responder_if
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DATA_W = DMEM_DATA_W
);

  logic              req_valid;
  logic              req_ready;
  mem_op_t           req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_valid, req_op, req_addr, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port tape storage with registered read;
// contents are not reset.
module dmem_array #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Tape responder: clears the array after reset, then
// serves RD/WR/INC/DEC one request at a time.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DATA_W = DMEM_DATA_W,
  parameter int unsigned DEPTH  = DMEM_DEPTH
) (
  input  logic            clk,
  input  logic            reset_n,
  dmem_responder_if.slave bus,
  output logic            busy
);

  rsp_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  mem_op_t           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] mod_val;

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk_i   (clk),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  assign mod_val = (op_q == INC)
                 ? mem_rdata + DATA_W'(1)
                 : mem_rdata - DATA_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_CLEAR;
      ptr_q      <= '0;
      op_q       <= RD;
      addr_q     <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    op_d       = op_q;
    addr_d     = addr_q;
    rsp_data_d = rsp_data_q;
    mem_we     = 1'b0;
    mem_addr   = addr_q;
    mem_wdata  = '0;
    unique case (state_q)
      S_CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = ptr_q;
        ptr_d    = ptr_q + ADDR_W'(1);
        if (ptr_q == ADDR_W'(DEPTH - 1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        // read is launched on the accept edge so data is ready in READ
        mem_addr = bus.req_addr;
        if (bus.req_valid) begin
          op_d   = bus.req_op;
          addr_d = bus.req_addr;
          if (bus.req_op == WR) begin
            mem_we     = 1'b1;
            mem_wdata  = bus.req_wdata;
            rsp_data_d = bus.req_wdata;
            state_d    = S_RESP;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (op_q == RD) begin
          rsp_data_d = mem_rdata;
          state_d    = S_RESP;
        end else begin
          state_d = S_MODIFY;
        end
      end
      S_MODIFY: begin
        mem_we     = 1'b1;
        mem_wdata  = mod_val;
        rsp_data_d = mod_val;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and scoreboard checks for dmem_responder:
// clear, op results, latency, backpressure, mid-op reset.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic busy;

  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  dmem_responder #(
    .ADDR_W (8),
    .DATA_W (8),
    .DEPTH  (256)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] model [256];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic do_op(input mem_op_t op,
                       input logic [7:0] a,
                       input logic [7:0] wd,
                       input logic [7:0] ex,
                       input int lat,
                       input string tag);
    int n;
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    n = 0;
    while (!bus.req_ready && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) check({tag, "_acc"}, 0, 1);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rsp_valid && n < 10);
    check({tag, "_lat"}, n, lat);
    check({tag, "_dat"}, bus.rsp_data, ex);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_clear(input string tag);
    int early = 0;
    int vld   = 0;
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      if (i < 256 && bus.req_ready) early++;
      if (bus.rsp_valid) vld++;
    end
    check({tag, "_early"}, early, 0);
    check({tag, "_ready"}, bus.req_ready, 1);
    check({tag, "_norsp"}, vld, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic   stable;
    mem_op_t op;
    logic [7:0] a, wd, ex;
    int lat;

    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = RD;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.req_ready, 0);
    check("rst_valid", bus.rsp_valid, 0);
    check("rst_data", bus.rsp_data, 0);
    check("rst_busy", busy, 1);
    reset_n = 1'b1;
    wait_clear("clr");

    do_op(RD, 8'h00, 8'h00, 8'h00, 2, "rd00");
    do_op(RD, 8'h7F, 8'h00, 8'h00, 2, "rd7f");
    do_op(RD, 8'hFF, 8'h00, 8'h00, 2, "rdff");

    do_op(WR, 8'h10, 8'h5A, 8'h5A, 1, "wr10");
    do_op(RD, 8'h10, 8'h00, 8'h5A, 2, "rd10");

    do_op(WR,  8'h20, 8'hFF, 8'hFF, 1, "wr20");
    do_op(INC, 8'h20, 8'h00, 8'h00, 3, "inc20");
    do_op(DEC, 8'h20, 8'h00, 8'hFF, 3, "dec20a");
    do_op(DEC, 8'h20, 8'h00, 8'hFE, 3, "dec20b");
    do_op(RD,  8'h20, 8'h00, 8'hFE, 2, "rd20");

    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_op    = RD;
    bus.req_addr  = 8'h10;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("hold_valid", bus.rsp_valid, 1);
    check("hold_data", bus.rsp_data, 8'h5A);
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_data !== 8'h5A
          || bus.req_ready) stable = 1'b0;
    end
    check("hold_stable", stable, 1);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("hold_single", bus.rsp_valid, 0);
    check("hold_idle", bus.req_ready, 1);

    do_op(WR, 8'h40, 8'h33, 8'h33, 1, "wr40");
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = INC;
    bus.req_addr  = 8'h40;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_state", 32'(dut.state_q), 32'(S_MODIFY));
    reset_n = 1'b0;
    #1;
    check("mid_valid", bus.rsp_valid, 0);
    check("mid_busy", busy, 1);
    check("mid_ready", bus.req_ready, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_clear("reclr");
    do_op(RD, 8'h40, 8'h00, 8'h00, 2, "rd40");

    foreach (model[i]) model[i] = 8'h00;
    for (int k = 0; k < 1000; k++) begin
      op = mem_op_t'($urandom_range(0, 3));
      a  = 8'($urandom_range(0, 31));
      wd = 8'($urandom);
      unique case (op)
        RD:  begin ex = model[a];         lat = 2; end
        WR:  begin ex = wd;               lat = 1; end
        INC: begin ex = model[a] + 8'd1;  lat = 3; end
        default: begin ex = model[a] - 8'd1; lat = 3; end
      endcase
      model[a] = ex;
      do_op(op, a, wd, ex, lat, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data-memory port. It owns the 256-byte tape, zero-fills it after reset, and serves read, write, increment and decrement requests over a valid/ready request channel and a valid/ready response channel. It sits between the core's memory-control logic and the storage array. Increment and decrement run as an internal read-modify-write, so the core issues one request per tape operation.

## Interface

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, cell width.
- DEPTH, 256, number of cells; equals 2**ADDR_W.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_op  in  2  operation, a mem_op_t value: RD, WR, INC, DEC.
- req_addr  in  ADDR_W  cell address.
- req_wdata  in  DATA_W  write data; used only by WR.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts the response.
- rsp_data  out  DATA_W  resulting cell value.
- busy  out  1  high during CLEAR or while a request is in flight.

## Operation

- A request is accepted on a cycle with req_valid && req_ready. The responder latches op, addr and wdata at that edge.
- Every request produces exactly one response.
- rsp_data for each operation:
  - RD: the stored value.
  - WR: req_wdata.
  - INC: old value + 1.
  - DEC: old value - 1.
- INC and DEC arithmetic is DATA_W-bit modular. 0xFF INC gives 0x00; 0x00 DEC gives 0xFF.
- The new value is written to the array before the response is presented.
- State machine states:
  - CLEAR: entered on reset. ptr goes 0 to DEPTH-1, writing 0 each cycle. After writing DEPTH-1, go to IDLE.
  - IDLE: req_ready=1. On accept: WR goes to RESP and writes on the accept edge. RD, INC and DEC go to READ.
  - READ: registered array read of the latched address. RD then goes to RESP. INC and DEC go to MODIFY.
  - MODIFY: compute ±1, write it back, load rsp_data, go to RESP.
  - RESP: rsp_valid=1. On rsp_ready, go to IDLE.
- req_ready is high only in IDLE, so there is one outstanding request.
- While rsp_valid=1 and rsp_ready=0, rsp_data stays stable and the request channel stays closed.
- Illegal op encodings cannot occur, because mem_op_t has four values for two bits.
- An address at or beyond DEPTH cannot occur, because DEPTH=2**ADDR_W.

## Timing

- Reset values, applied asynchronously:
  - State = CLEAR, ptr=0.
  - req_ready=0, rsp_valid=0, rsp_data=0, busy=1.
- CLEAR lasts DEPTH cycles after reset deassertion. req_ready first rises on cycle DEPTH.
- Latency from the accept edge to the first cycle rsp_valid is high:
  - WR: 1 cycle.
  - RD: 2 cycles.
  - INC and DEC: 3 cycles.
- Back-to-back throughput: the next accept happens no earlier than the cycle after the response handshake, because RESP returns to IDLE first.
- Reset asserted mid-operation: any in-flight request is dropped with no response, rsp_valid falls immediately, and CLEAR restarts from ptr=0. A write in progress on the reset edge may or may not land; CLEAR overwrites it anyway.
- Array contents are not reset directly; CLEAR establishes all zeros.

## Structure

- Add the mem_op_t enum (RD=0, WR=1, INC=2, DEC=3) to the shared definitions package.
- Add the responder state enum to the same package for bench visibility.
- One sub-module, dmem_array: synchronous single-port DEPTH×DATA_W RAM with a registered read and a write enable. It has no reset.
- The FSM, the clear pointer and the modify adder stay in dmem_responder.

## Test plan

- Reset, then poll: req_ready stays 0 for 256 cycles. RD of addresses 0x00, 0x7F and 0xFF each return 0x00.
- WR 0x5A to 0x10, then RD 0x10: WR response 1 cycle after accept with data 0x5A; RD returns 0x5A 2 cycles after accept.
- WR 0xFF to 0x20, INC 0x20, then DEC 0x20 twice:
  - INC responds 0x00, 3 cycles after accept.
  - DECs respond 0xFF, then 0xFE.
  - A final RD returns 0xFE.
- Issue RD with rsp_ready held 0 for 5 cycles:
  - rsp_valid and rsp_data stay stable throughout.
  - req_ready stays 0.
  - One response only, when rsp_ready rises.
- Assert reset_n low during INC MODIFY:
  - rsp_valid drops the same cycle.
  - No response is produced.
  - CLEAR reruns; a later RD of the target address returns 0x00.
- Random mix of 1000 ops checked against a scoreboard model: every response and latency matches.
